mcycle_iter_unit: RTL
=====================

# mcycle_iter_unit

Parametrised multi-cycle multiply/divide unit: the successor to the single-mode shift sequencer, with its own operand/result datapath, signed/unsigned modes and divide-by-zero handling. It sits beside the ALU in the execute stage. The unit captures operands on a Start handshake, iterates one bit per clock, and returns a double-width product or a quotient/remainder pair with a one-cycle Done pulse.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

- CLK  in  1  clock; all state updates on rising edge
- ResetN  in  1  synchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- MCycleOp  in  1  0 = multiply, 1 = divide
- Signed  in  1  1 = two's-complement operands, 0 = unsigned
- Operand1  in  WIDTH  multiplicand / dividend
- Operand2  in  WIDTH  multiplier / divisor
- Result1  out  WIDTH  product low half / quotient
- Result2  out  WIDTH  product high half / remainder
- Busy  out  1  operation in progress (registered)
- Done  out  1  one-cycle pulse; results valid
- DivByZero  out  1  set with Done when divide had Operand2 == 0; held until next accepted Start

## Operation
- States: IDLE, COMPUTE, FIX.
- IDLE:
  - Start=1 → capture MCycleOp, Signed, operand magnitudes and operand signs (abs value when Signed and MSB=1); clear counter.
  - Go to COMPUTE, or straight to FIX if divide and Operand2 == 0.
- COMPUTE: one iteration per cycle, WIDTH cycles; counter runs 0..WIDTH-1, then → FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes (WIDTH+1-bit partial remainder).
- FIX: one cycle; apply signs, write Result1/Result2, pulse Done → IDLE.
  - Multiply: negate the 2·WIDTH product if Signed and sign1≠sign2.
  - Divide: negate the quotient if Signed and sign1≠sign2; negate the remainder if Signed and sign1=1.
  - Divide by zero: Result1 = all ones, Result2 = Operand1 as captured, DivByZero=1.
- Signed overflow (most-negative / -1): Result1 = most-negative, Result2 = 0; no flag.
- Operand/mode inputs are ignored after capture. Start while Busy is ignored, with no queueing.
- Result1/Result2 hold their last values until the next FIX. They are not cleared at Start.

## Timing
- Start sampled high in cycle 0 (IDLE):
  - Busy=1 in cycles 1..WIDTH+1.
  - COMPUTE in cycles 1..WIDTH, FIX in cycle WIDTH+1.
  - Done=1, Busy=0 and results valid in cycle WIDTH+2.
  - Total latency is WIDTH+2 cycles.
- Divide by zero: FIX in cycle 1; Done and results in cycle 2.
- Done lasts exactly one cycle. The state is IDLE during the Done cycle, so Start in that cycle is accepted (back-to-back). The new Busy rises in the next cycle.
- Reset (ResetN=0 at a rising edge) has priority over everything:
  - State → IDLE, counter 0.
  - Busy, Done, DivByZero, Result1 and Result2 all go to 0.
  - Start in a reset cycle is ignored.
  - Reset mid-COMPUTE aborts with no Done.
- Reset values of all outputs are 0.

## Test plan
- WIDTH=32, unsigned multiply 7×6 → Result1=0x0000002A, Result2=0; Done in cycle 34 only; Busy high in cycles 1–33.
- Unsigned multiply 0xFFFFFFFF×0xFFFFFFFF → Result2=0xFFFFFFFE, Result1=0x00000001. Signed multiply −3×5 → Result2=0xFFFFFFFF, Result1=0xFFFFFFF1.
- Signed divide −7/2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Unsigned divide 100/7 → Result1=14, Result2=2. Signed divide 0x80000000/−1 → Result1=0x80000000, Result2=0.
- Divide 100/0 (either mode) → Done in cycle 2, Result1=0xFFFFFFFF, Result2=100, DivByZero=1. DivByZero clears on the next accepted Start.
- Back-to-back: Start held high continuously → Done every 34 cycles. Start pulses while Busy are ignored. Operand changes mid-operation do not alter results.
- ResetN low in cycle 10 of a multiply → cycle 11: Busy=0, Done=0, results 0, and no Done ever follows. A new Start after reset completes normally. Also repeat 7×6 at WIDTH=8: Done in cycle 10.

Source files
------------

// File: rtl/mcycle_iter_unit.sv
// Iterative multiply/divide unit: one bit per clock, signed or unsigned operands,
// double-width product or quotient/remainder, divide-by-zero reported with Done.
module mcycle_iter_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    localparam int unsigned      PROD_W   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             is_signed;
    logic             sign1;
    logic             sign2;
    logic             div_zero;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] op1_raw;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0]  abs1;
    logic [WIDTH-1:0]  abs2;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH-1:0]  div_diff;
    logic              div_ge;
    logic              neg_res;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    // Operand magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude
    assign abs1 = (Signed && Operand1[WIDTH-1]) ? WIDTH'(-Operand1) : Operand1;
    assign abs2 = (Signed && Operand2[WIDTH-1]) ? WIDTH'(-Operand2) : Operand2;

    // acc_hi:acc_lo is the product register for multiply, remainder:quotient for divide
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag1} : {(WIDTH + 1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag2});
    assign div_diff  = WIDTH'(div_shift - {1'b0, mag2});

    // Sign fix-up; most-negative / -1 falls out naturally as most-negative rem 0
    assign neg_res  = is_signed && (sign1 != sign2);
    assign product  = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? PROD_W'(-product) : product;
    assign quo_fix  = neg_res ? WIDTH'(-acc_lo) : acc_lo;
    assign rem_fix  = (is_signed && sign1) ? WIDTH'(-acc_hi) : acc_hi;

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            div_zero  <= 1'b0;
            mag1      <= '0;
            mag2      <= '0;
            op1_raw   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            Result1   <= '0;
            Result2   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        is_div    <= MCycleOp;
                        is_signed <= Signed;
                        sign1     <= Signed && Operand1[WIDTH-1];
                        sign2     <= Signed && Operand2[WIDTH-1];
                        div_zero  <= MCycleOp && (Operand2 == '0);
                        mag1      <= abs1;
                        mag2      <= abs2;
                        op1_raw   <= Operand1;
                        acc_hi    <= '0;
                        acc_lo    <= MCycleOp ? abs1 : abs2;
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        DivByZero <= 1'b0;
                        state     <= (MCycleOp && (Operand2 == '0)) ? FIX : COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (!is_div) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (div_ge) begin
                        acc_hi <= div_diff;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        Result1   <= '1;
                        Result2   <= op1_raw;
                        DivByZero <= 1'b1;
                    end else if (is_div) begin
                        Result1 <= quo_fix;
                        Result2 <= rem_fix;
                    end else begin
                        Result1 <= prod_fix[WIDTH-1:0];
                        Result2 <= prod_fix[PROD_W-1:WIDTH];
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
